res_ttl_pulse_counter: RTL and testbench

Multi-channel TTL pulse counter. Counts selected edges on N_CH asynchronous res_ttl inputs inside a measurement window of WIN_DIV periods of the clk_1Mz reference. At each window close it latches all counts as one parallel snapshot with a valid strobe. Test/diagnostic path in the clk_100Mz domain; generalises the single-channel falling-edge-per-1 MHz-period counter.

---
 rtl/res_ttl_pulse_counter.sv | 73 +++++++
 tb/tb_res_ttl_pulse_counter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/res_ttl_pulse_counter.sv
// res_ttl_pulse_counter: windowed multi-channel TTL edge counter with parallel snapshot
module res_ttl_pulse_counter #(
  parameter int N_CH = 4,
  parameter int CNT_W = 8,
  parameter int WIN_DIV = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_100Mz,
  input  logic                   sbros,
  input  logic                   clk_1Mz,
  input  logic [N_CH-1:0]        res_ttl_in,
  input  logic [2*N_CH-1:0]      edge_mode,
  output logic [N_CH*CNT_W-1:0]  cnt_form_res_ttl,
  output logic                   cnt_valid,
  output logic [N_CH-1:0]        ovf
);
  localparam int WW = WIN_DIV > 1 ? $clog2(WIN_DIV) : 1;
  logic [SYNC_STAGES-1:0][N_CH:0] sync_q, sync_d;
  logic [N_CH:0] hist_q, hist_d, rise, fall;
  logic armed_q, armed_d, valid_q, valid_d, gate, close;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [N_CH-1:0][CNT_W-1:0] acc_q, acc_d, nxt, cnt_q, cnt_d;
  logic [N_CH-1:0] ovf_acc_q, ovf_acc_d, ovf_n, ovf_q, ovf_d, inc;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], clk_1Mz, res_ttl_in};
    hist_d = sync_q[SYNC_STAGES-1];
    rise = hist_d & ~hist_q;
    fall = ~hist_d & hist_q;
    gate = rise[N_CH];
    close = armed_q && gate && win_cnt_q == WW'(WIN_DIV - 1);
    armed_d = armed_q | gate;
    win_cnt_d = (!armed_q || close) ? '0 : gate ? win_cnt_q + WW'(1) : win_cnt_q;
    valid_d = close;
    nxt = acc_q;
    ovf_n = ovf_acc_q;
    inc = '0;
    for (int i = 0; i < N_CH; i++) begin
      inc[i] = armed_q & ((edge_mode[2*i] & rise[i]) | (edge_mode[2*i+1] & fall[i]));
      nxt[i] = acc_q[i] + CNT_W'(inc[i] & ~(&acc_q[i]));
      ovf_n[i] = ovf_acc_q[i] | (inc[i] & (&acc_q[i]));
    end
    acc_d = (!armed_q || close) ? '0 : nxt;
    ovf_acc_d = (!armed_q || close) ? '0 : ovf_n;
    cnt_d = close ? nxt : cnt_q;
    ovf_d = close ? ovf_n : ovf_q;
  end
  always_ff @(posedge clk_100Mz) begin
    if (sbros) begin
      sync_q <= '0;
      hist_q <= '0;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      win_cnt_q <= '0;
      acc_q <= '0;
      ovf_acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      armed_q <= armed_d;
      valid_q <= valid_d;
      win_cnt_q <= win_cnt_d;
      acc_q <= acc_d;
      ovf_acc_q <= ovf_acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign cnt_form_res_ttl = cnt_q;
  assign cnt_valid = valid_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_res_ttl_pulse_counter.sv
// tb_res_ttl_pulse_counter: directed self-checking bench for res_ttl_pulse_counter
module tb_res_ttl_pulse_counter;
  logic clk = 1'b0;
  logic sbros = 1'b1;
  logic clk_1Mz = 1'b0;
  logic [3:0] res_ttl_in = '0;
  logic [7:0] edge_mode = '0;
  logic [31:0] cnt, cnt8;
  logic valid, valid8;
  logic [3:0] ovf, ovf8;
  int n_chk = 0;
  int n_fail = 0;
  int w8 = 0;
  bit armed = 1'b0;
  res_ttl_pulse_counter u_dut (
    .clk_100Mz(clk),
    .sbros(sbros),
    .clk_1Mz(clk_1Mz),
    .res_ttl_in(res_ttl_in),
    .edge_mode(edge_mode),
    .cnt_form_res_ttl(cnt),
    .cnt_valid(valid),
    .ovf(ovf)
  );
  res_ttl_pulse_counter #(.WIN_DIV(8)) u_w8 (
    .clk_100Mz(clk),
    .sbros(sbros),
    .clk_1Mz(clk_1Mz),
    .res_ttl_in(res_ttl_in),
    .edge_mode(edge_mode),
    .cnt_form_res_ttl(cnt8),
    .cnt_valid(valid8),
    .ovf(ovf8)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic rst();
    sbros = 1'b1;
    tick();
    sbros = 1'b0;
    armed = 1'b0;
    w8 = 0;
  endtask
  task automatic pulses(input logic [3:0] mask, input int n);
    repeat (n) begin
      res_ttl_in = res_ttl_in | mask;
      tick();
      tick();
      res_ttl_in = res_ttl_in & ~mask;
      tick();
      tick();
    end
  endtask
  task automatic toggle(input logic [3:0] mask, input int n);
    repeat (n) begin
      res_ttl_in = res_ttl_in ^ mask;
      tick();
    end
  endtask
  task automatic gate(input logic [3:0] flip);
    bit e1, e8;
    e1 = armed;
    e8 = armed && w8 == 7;
    if (armed) w8 = (w8 + 1) % 8;
    armed = 1'b1;
    clk_1Mz = 1'b1;
    res_ttl_in = res_ttl_in ^ flip;
    tick();
    tick();
    chk("valid_early", valid, 0);
    chk("valid8_early", valid8, 0);
    tick();
    chk("valid", valid, e1);
    chk("valid8", valid8, e8);
    clk_1Mz = 1'b0;
    tick();
    chk("valid_pulse", valid, 0);
    chk("valid8_pulse", valid8, 0);
    tick();
  endtask
  initial begin
    rst();
    chk("rst_cnt", cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_valid", valid, 0);
    chk("rst_cnt8", cnt8, 0);
    chk("rst_ovf8", ovf8, 0);
    edge_mode = 8'h02;
    gate(4'h0);
    chk("arm_no_snap", cnt, 0);
    pulses(4'h1, 5);
    idle(75);
    gate(4'h0);
    chk("fall_win1", cnt, 32'h0000_0005);
    chk("fall_win1_ovf", ovf, 0);
    pulses(4'h1, 5);
    idle(75);
    gate(4'h0);
    chk("fall_win2", cnt, 32'h0000_0005);
    edge_mode = 8'h1C;
    pulses(4'hF, 5);
    gate(4'h0);
    chk("modes", cnt, 32'h0005_0A00);
    chk("modes_ovf", ovf, 0);
    edge_mode = 8'h02;
    pulses(4'h1, 4);
    res_ttl_in[0] = 1'b1;
    tick();
    tick();
    gate(4'h1);
    chk("coinc_close", cnt, 32'h0000_0005);
    gate(4'h0);
    chk("coinc_next", cnt, 32'h0000_0000);
    pulses(4'h1, 7);
    gate(4'h0);
    chk("pre_rst_snap", cnt, 32'h0000_0007);
    pulses(4'h1, 7);
    rst();
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_ovf", ovf, 0);
    pulses(4'h1, 2);
    gate(4'h0);
    pulses(4'h1, 3);
    gate(4'h0);
    chk("rearm_snap", cnt, 32'h0000_0003);
    edge_mode = 8'h01;
    res_ttl_in = 4'h1;
    rst();
    idle(5);
    gate(4'h0);
    idle(10);
    gate(4'h0);
    chk("stuck_hi_win1", cnt, 0);
    gate(4'h0);
    chk("stuck_hi_win2", cnt, 0);
    res_ttl_in = 4'h0;
    edge_mode = 8'h03;
    rst();
    gate(4'h0);
    toggle(4'h1, 300);
    gate(4'h0);
    chk("sat_main", cnt, 32'h0000_00FF);
    chk("sat_main_ovf", ovf, 4'h1);
    repeat (7) gate(4'h0);
    chk("sat_w8", cnt8, 32'h0000_00FF);
    chk("sat_w8_ovf", ovf8, 4'h1);
    chk("main_ovf_clr", ovf, 0);
    chk("main_cnt_clr", cnt, 0);
    toggle(4'h1, 1);
    gate(4'h0);
    chk("main_one", cnt, 32'h0000_0001);
    gate(4'h0);
    gate(4'h0);
    chk("w8_hold", cnt8, 32'h0000_00FF);
    toggle(4'h1, 2);
    repeat (5) gate(4'h0);
    chk("w8_after_sat", cnt8, 32'h0000_0003);
    chk("w8_after_sat_ovf", ovf8, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
